spi_cmd_sequencer: RTL and testbench
====================================

Name: spi_cmd_sequencer

Overview:
- Command-level controller behind the SPI slave byte datapath.
- Consumes received-byte strobes and the chip-select framing, decodes a byte-oriented command protocol, and sequences register-bank reads and writes over a req/ack handshake.
- Supplies the next transmit byte to the SPI slave shift register.
- Frame format: opcode byte, address byte, then a streaming data phase with address auto-increment.

Parameters:
ADDR_W, 7, register address width; address wraps modulo 2^ADDR_W
TIMEOUT_CYC, 255, ack timeout in clk cycles (used only with SPI_CMD_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  reset
sel_active  in  1  chip select active, already synchronised to clk
rx_valid  in  1  one-cycle pulse: a full byte has been received
rx_data  in  8  received byte, valid with rx_valid
tx_data  out  8  byte the SPI slave shifts out next
tx_load  out  1  one-cycle pulse: tx_data updated
reg_req  out  1  register access request
reg_we  out  1  1 = write, 0 = read; valid while reg_req
reg_addr  out  ADDR_W  access address
reg_wdata  out  8  write data
reg_ack  in  1  access complete; reg_rdata valid on the same cycle for reads
reg_rdata  in  8  read data
busy  out  1  state != IDLE
err  out  1  sticky protocol/timeout error

Behaviour:
- Single clock clk. Reset rst is synchronous and active-high.
- Reset values: all outputs 0, tx_data 0x00, state IDLE, sticky flags err and ovr 0.
- Opcodes: 0x01 WRITE, 0x02 READ, 0x03 STATUS. Any other opcode sets err and enters DRAIN.
- States: IDLE, ADDR, WR_DATA, WR_WAIT, RD_WAIT, RD_STREAM, STATUS, DRAIN.
- IDLE: waits for sel_active=1 plus rx_valid (the opcode byte).
  - WRITE or READ -> ADDR.
  - STATUS -> STATUS. Same cycle: tx_data={err,ovr,6'h2A}, tx_load=1.
- ADDR: on rx_valid, reg_addr <= rx_data[ADDR_W-1:0].
  - WRITE -> WR_DATA.
  - READ -> RD_WAIT, asserting reg_req=1, reg_we=0 the next cycle.
- WR_DATA: each rx_valid -> reg_wdata <= rx_data, reg_req=1, reg_we=1 -> WR_WAIT.
- WR_WAIT: reg_req held until reg_ack is sampled high.
  - Then reg_req=0, reg_addr increments with wrap (2^ADDR_W-1 -> 0), state -> WR_DATA.
- RD_WAIT: reg_req held until reg_ack.
  - Next cycle: tx_data <= reg_rdata, tx_load=1, reg_addr increments, state -> RD_STREAM.
- RD_STREAM: each rx_valid (dummy byte) issues the next read -> RD_WAIT.
- STATUS: the status byte is presented once. Further rx_valid is ignored. On deselect, err and ovr clear.
- Handshake rules:
  - reg_req rises at most one cycle after its trigger.
  - reg_addr, reg_we and reg_wdata are stable while reg_req=1.
  - reg_req drops the cycle after ack.
  - Back-to-back accesses have at least one idle cycle between them.
- Overrun: rx_valid while in WR_WAIT or RD_WAIT sets ovr and err, and the byte is dropped. The pending access completes normally.
- Deselect (sel_active 1->0) in any state:
  - With no access pending: next state IDLE, tx_data <= 0x00.
  - With an access pending: reg_req stays asserted until ack, read data is discarded (no tx_load), then IDLE.
- DRAIN: ignores all bytes until deselect, then IDLE.
- rst mid-transaction: immediate return to reset values, with reg_req dropped without waiting for ack.
- A simultaneous rx_valid and deselect cycle is treated as deselect; the byte is dropped and no flag is set.

Optional Feature:
- Macro: SPI_CMD_TIMEOUT_EN.
- Defined:
  - An 8+-bit counter runs while reg_req=1.
  - Reaching TIMEOUT_CYC without ack: reg_req drops, err is set, state -> DRAIN.
  - A late ack is ignored.
- Undefined: no counter; waits for ack indefinitely.

Decomposition:
- Package spi_cmd_pkg holds:
  - the opcode localparams (OP_WRITE=8'h01, OP_READ=8'h02, OP_STATUS=8'h03)
  - the STATUS_ID constant 6'h2A
  - the state enum typedef
- No sub-module. The address counter and timeout counter stay inline.

Test Plan:
- Write burst: sel, bytes 01,10,AA,BB, acks after 2 cycles -> writes (0x10,AA) then (0x11,BB); err=0, busy=0 after deselect.
- Read burst with ADDR_W=7: bytes 02,7F,00,00; rdata 0x5C then 0x3D -> tx_load pulses with tx_data 5C, 3D; reg_addr 7F then wraps to 00.
- Bad opcode 0x55: err=1, then STATUS frame (03) -> tx_data 0xAA ({err=1,ovr=0,6'h2A}); after deselect, next STATUS frame -> 0x2A.
- Overrun: WRITE with ack delayed 40 cycles while a data byte arrives -> ovr=1, err=1, only the first write issued.
- Deselect during RD_WAIT: req held until ack, no tx_load, busy=0 the cycle after ack. Also rst asserted mid-write -> reg_req=0 next cycle.
- With SPI_CMD_TIMEOUT_EN and TIMEOUT_CYC=16, ack never given -> reg_req drops after 16 cycles, err=1, later bytes ignored until deselect.

Source files
------------

// File: rtl/spi_cmd_sequencer_pkg.sv
// Shared constants for the SPI command sequencer: opcodes, status ID byte and FSM state encoding.
package spi_cmd_pkg;

  localparam logic [7:0] OP_WRITE  = 8'h01;
  localparam logic [7:0] OP_READ   = 8'h02;
  localparam logic [7:0] OP_STATUS = 8'h03;

  localparam logic [5:0] STATUS_ID = 6'h2A;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_WR_DATA,
    ST_WR_WAIT,
    ST_RD_WAIT,
    ST_RD_STREAM,
    ST_STATUS,
    ST_DRAIN
  } state_t;

endpackage

// File: rtl/spi_cmd_sequencer.sv
// Decodes SPI command frames (opcode, address, streaming data) into register-bank req/ack accesses.
// Optional ack watchdog enabled by defining SPI_CMD_TIMEOUT_EN.
module spi_cmd_sequencer
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_W      = 7,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sel_active,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic [7:0]        tx_data,
  output logic              tx_load,
  output logic              reg_req,
  output logic              reg_we,
  output logic [ADDR_W-1:0] reg_addr,
  output logic [7:0]        reg_wdata,
  input  logic              reg_ack,
  input  logic [7:0]        reg_rdata,
  output logic              busy,
  output logic              err
);

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  state_t state;
  logic   ovr;
  logic   is_read;
  // Set when the master deselects while an access is still outstanding.
  logic   abort;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int TO_W = ($clog2(TIMEOUT_CYC + 1) > 8) ? $clog2(TIMEOUT_CYC + 1) : 8;
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
  logic [TO_W-1:0] to_cnt;
  logic            to_hit;
  assign to_hit = (to_cnt == TO_LAST);
`endif

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      tx_data   <= 8'h00;
      tx_load   <= 1'b0;
      reg_req   <= 1'b0;
      reg_we    <= 1'b0;
      reg_addr  <= '0;
      reg_wdata <= 8'h00;
      err       <= 1'b0;
      ovr       <= 1'b0;
      is_read   <= 1'b0;
      abort     <= 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
      to_cnt    <= '0;
`endif
    end else begin
      tx_load <= 1'b0;
`ifdef SPI_CMD_TIMEOUT_EN
      if (reg_req && !reg_ack) to_cnt <= to_cnt + 1'b1;
      else                     to_cnt <= '0;
`endif
      case (state)
        ST_IDLE: begin
          if (sel_active && rx_valid) begin
            if (rx_data == OP_WRITE) begin
              is_read <= 1'b0;
              state   <= ST_ADDR;
            end else if (rx_data == OP_READ) begin
              is_read <= 1'b1;
              state   <= ST_ADDR;
            end else if (rx_data == OP_STATUS) begin
              tx_data <= {err, ovr, STATUS_ID};
              tx_load <= 1'b1;
              state   <= ST_STATUS;
            end else begin
              err   <= 1'b1;
              state <= ST_DRAIN;
            end
          end
        end

        ST_ADDR: begin
          if (!sel_active) begin
            state   <= ST_IDLE;
            tx_data <= 8'h00;
          end else if (rx_valid) begin
            reg_addr <= rx_data[ADDR_W-1:0];
            if (is_read) begin
              reg_req <= 1'b1;
              reg_we  <= 1'b0;
              state   <= ST_RD_WAIT;
            end else begin
              state <= ST_WR_DATA;
            end
          end
        end

        ST_WR_DATA: begin
          if (!sel_active) begin
            state   <= ST_IDLE;
            tx_data <= 8'h00;
          end else if (rx_valid) begin
            reg_wdata <= rx_data;
            reg_req   <= 1'b1;
            reg_we    <= 1'b1;
            state     <= ST_WR_WAIT;
          end
        end

        ST_WR_WAIT, ST_RD_WAIT: begin
          // A byte arriving mid-access is dropped; a deselect only defers the exit.
          if (!sel_active)   abort <= 1'b1;
          else if (rx_valid) begin
            ovr <= 1'b1;
            err <= 1'b1;
          end
          if (reg_ack) begin
            reg_req <= 1'b0;
            if (abort || !sel_active) begin
              abort   <= 1'b0;
              tx_data <= 8'h00;
              state   <= ST_IDLE;
            end else begin
              reg_addr <= reg_addr + ADDR_ONE;
              if (state == ST_RD_WAIT) begin
                tx_data <= reg_rdata;
                tx_load <= 1'b1;
                state   <= ST_RD_STREAM;
              end else begin
                state <= ST_WR_DATA;
              end
            end
          end
`ifdef SPI_CMD_TIMEOUT_EN
          else if (to_hit) begin
            reg_req <= 1'b0;
            err     <= 1'b1;
            abort   <= 1'b0;
            state   <= ST_DRAIN;
          end
`endif
        end

        ST_RD_STREAM: begin
          if (!sel_active) begin
            state   <= ST_IDLE;
            tx_data <= 8'h00;
          end else if (rx_valid) begin
            reg_req <= 1'b1;
            reg_we  <= 1'b0;
            state   <= ST_RD_WAIT;
          end
        end

        ST_STATUS: begin
          if (!sel_active) begin
            err     <= 1'b0;
            ovr     <= 1'b0;
            tx_data <= 8'h00;
            state   <= ST_IDLE;
          end
        end

        ST_DRAIN: begin
          if (!sel_active) begin
            tx_data <= 8'h00;
            state   <= ST_IDLE;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_spi_cmd_sequencer.sv
// Directed bench for spi_cmd_sequencer: write/read bursts, status, overrun, deselect, reset, timeout.
module tb_spi_cmd_sequencer;

  logic       clk = 1'b0;
  logic       rst;
  logic       sel_active;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] tx_data;
  logic       tx_load;
  logic       reg_req;
  logic       reg_we;
  logic [6:0] reg_addr;
  logic [7:0] reg_wdata;
  logic       reg_ack;
  logic [7:0] reg_rdata;
  logic       busy;
  logic       err;

  int vec_cnt  = 0;
  int miss_cnt = 0;

  // responder controls and logs
  int         ack_delay = 2;
  bit         ack_en    = 1'b1;
  int         wait_cnt  = 0;
  int         stab_err  = 0;
  logic       req_prev  = 1'b0;
  logic [6:0] snap_addr;
  logic       snap_we;
  logic [7:0] snap_wdata;
  logic [7:0] rd_q[$];
  logic [6:0] acc_addr[$];
  logic       acc_we[$];
  logic [7:0] acc_wdata[$];
  logic [7:0] tx_log[$];

  spi_cmd_sequencer #(.ADDR_W(7), .TIMEOUT_CYC(16)) dut (
    .clk(clk), .rst(rst), .sel_active(sel_active), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_data(tx_data), .tx_load(tx_load), .reg_req(reg_req), .reg_we(reg_we),
    .reg_addr(reg_addr), .reg_wdata(reg_wdata), .reg_ack(reg_ack), .reg_rdata(reg_rdata),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  // Register-bank model: acks after ack_delay cycles, logs accesses and tx loads.
  initial begin
    reg_ack   = 1'b0;
    reg_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (tx_load) tx_log.push_back(tx_data);
      if (reg_req && !req_prev) begin
        snap_addr = reg_addr; snap_we = reg_we; snap_wdata = reg_wdata;
      end else if (reg_req && req_prev) begin
        if (reg_addr !== snap_addr || reg_we !== snap_we || reg_wdata !== snap_wdata)
          stab_err++;
      end
      req_prev = reg_req;
      if (reg_ack) begin
        reg_ack = 1'b0;
      end else if (reg_req && ack_en) begin
        if (wait_cnt >= ack_delay) begin
          reg_ack   = 1'b1;
          reg_rdata = (rd_q.size() > 0) ? rd_q.pop_front() : 8'h00;
          acc_addr.push_back(reg_addr);
          acc_we.push_back(reg_we);
          acc_wdata.push_back(reg_wdata);
          wait_cnt = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, got hang, expected completion");
    $fatal(1);
  end

  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap = 8);
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
    cycles(gap);
  endtask

  task automatic clear_logs();
    acc_addr.delete(); acc_we.delete(); acc_wdata.delete(); tx_log.delete(); rd_q.delete();
  endtask

  task automatic wait_acc(input int n, input string name);
    int k = 0;
    while (acc_addr.size() < n && k < 300) begin
      @(negedge clk);
      k++;
    end
    vec_cnt++;
    if (acc_addr.size() < n) begin
      $display("FAIL %s: got %0d accesses, expected %0d", name, acc_addr.size(), n);
      miss_cnt++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; sel_active = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    cycles(3);
    vec_cnt++;
    if ({reg_req, reg_we, reg_addr, reg_wdata, tx_load} !== 18'h0) begin
      $display("FAIL reset_reg: got req=%b we=%b addr=%h wdata=%h load=%b, expected all 0",
               reg_req, reg_we, reg_addr, reg_wdata, tx_load);
      miss_cnt++;
    end
    vec_cnt++;
    if ({tx_data, busy, err} !== 10'h0) begin
      $display("FAIL reset_status: got tx=%h busy=%b err=%b, expected 00/0/0", tx_data, busy, err);
      miss_cnt++;
    end
    rst = 1'b0;
    cycles(2);
  endtask

  task automatic test_write_burst();
    clear_logs();
    ack_delay = 2;
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h01); send_byte(8'h10); send_byte(8'hAA); send_byte(8'hBB);
    wait_acc(2, "wr_count");
    cycles(4);
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    vec_cnt++;
    if (acc_addr.size() != 2 || acc_addr[0] !== 7'h10 || acc_wdata[0] !== 8'hAA || acc_we[0] !== 1'b1) begin
      $display("FAIL wr_first: got n=%0d addr=%h data=%h we=%b, expected 10/AA/1",
               acc_addr.size(), acc_addr[0], acc_wdata[0], acc_we[0]);
      miss_cnt++;
    end
    vec_cnt++;
    if (acc_addr.size() != 2 || acc_addr[1] !== 7'h11 || acc_wdata[1] !== 8'hBB || acc_we[1] !== 1'b1) begin
      $display("FAIL wr_second: got addr=%h data=%h we=%b, expected 11/BB/1",
               acc_addr[1], acc_wdata[1], acc_we[1]);
      miss_cnt++;
    end
    vec_cnt++;
    if (err !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL wr_end: got err=%b busy=%b, expected 0/0", err, busy);
      miss_cnt++;
    end
  endtask

  task automatic test_read_burst();
    clear_logs();
    rd_q.push_back(8'h5C); rd_q.push_back(8'h3D); rd_q.push_back(8'hE7);
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h02); send_byte(8'h7F); send_byte(8'h00); send_byte(8'h00);
    wait_acc(3, "rd_count");
    cycles(3);
    vec_cnt++;
    if (tx_log.size() != 3 || tx_log[0] !== 8'h5C || tx_log[1] !== 8'h3D || tx_log[2] !== 8'hE7) begin
      $display("FAIL rd_tx: got n=%0d %h %h %h, expected 3 loads 5C 3D E7",
               tx_log.size(), tx_log[0], tx_log[1], tx_log[2]);
      miss_cnt++;
    end
    vec_cnt++;
    if (acc_addr[0] !== 7'h7F || acc_addr[1] !== 7'h00 || acc_addr[2] !== 7'h01 || acc_we[0] !== 1'b0) begin
      $display("FAIL rd_addr: got %h %h %h we=%b, expected 7F 00 01 we=0",
               acc_addr[0], acc_addr[1], acc_addr[2], acc_we[0]);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    vec_cnt++;
    if (tx_data !== 8'h00 || busy !== 1'b0) begin
      $display("FAIL rd_desel: got tx=%h busy=%b, expected 00/0", tx_data, busy);
      miss_cnt++;
    end
  endtask

  task automatic test_bad_opcode_status();
    clear_logs();
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h55); send_byte(8'h01); send_byte(8'h10);
    vec_cnt++;
    if (err !== 1'b1 || busy !== 1'b1 || reg_req !== 1'b0) begin
      $display("FAIL bad_op: got err=%b busy=%b req=%b, expected 1/1/0", err, busy, reg_req);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h03); send_byte(8'h00);
    vec_cnt++;
    if (tx_log.size() != 1 || tx_data !== 8'hAA) begin
      $display("FAIL status_err: got n=%0d tx=%h, expected 1 load of AA", tx_log.size(), tx_data);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    vec_cnt++;
    if (err !== 1'b0) begin
      $display("FAIL status_clr: got err=%b, expected 0", err);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h03);
    vec_cnt++;
    if (tx_log.size() != 2 || tx_data !== 8'h2A) begin
      $display("FAIL status_clean: got n=%0d tx=%h, expected 2 loads, now 2A", tx_log.size(), tx_data);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
  endtask

  task automatic test_overrun();
    clear_logs();
    ack_delay = 40;
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h01); send_byte(8'h20); send_byte(8'h11); send_byte(8'h22);
    cycles(60);
    vec_cnt++;
    if (acc_addr.size() != 1 || acc_addr[0] !== 7'h20 || acc_wdata[0] !== 8'h11) begin
      $display("FAIL ovr_writes: got n=%0d addr=%h data=%h, expected 1 write 20/11",
               acc_addr.size(), acc_addr[0], acc_wdata[0]);
      miss_cnt++;
    end
    vec_cnt++;
    if (err !== 1'b1) begin
      $display("FAIL ovr_err: got err=%b, expected 1", err);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h03);
    vec_cnt++;
    if (tx_data !== 8'hEA) begin
      $display("FAIL ovr_status: got tx=%h, expected EA", tx_data);
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    ack_delay = 2;
  endtask

  task automatic test_deselect_rd_wait();
    int loads;
    clear_logs();
    ack_delay = 20;
    rd_q.push_back(8'h99);
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h02); send_byte(8'h40, 2);
    @(negedge clk) sel_active = 1'b0;
    cycles(3);
    loads = tx_log.size();
    vec_cnt++;
    if (reg_req !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL desel_hold: got req=%b busy=%b, expected 1/1", reg_req, busy);
      miss_cnt++;
    end
    wait_acc(1, "desel_ack");
    @(negedge clk);
    vec_cnt++;
    if (busy !== 1'b0 || reg_req !== 1'b0 || tx_log.size() != loads || tx_data !== 8'h00) begin
      $display("FAIL desel_done: got busy=%b req=%b loads=%0d tx=%h, expected 0/0/%0d/00",
               busy, reg_req, tx_log.size(), tx_data, loads);
      miss_cnt++;
    end
    ack_delay = 2;
  endtask

  task automatic test_rst_mid_write();
    int k = 0;
    clear_logs();
    ack_delay = 50;
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h01, 2); send_byte(8'h30, 2); send_byte(8'h77, 0);
    while (!reg_req && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    vec_cnt++;
    if (reg_req !== 1'b0 || busy !== 1'b0 || reg_addr !== 7'h00 || reg_wdata !== 8'h00) begin
      $display("FAIL rst_mid: got req=%b busy=%b addr=%h wdata=%h, expected 0/0/00/00",
               reg_req, busy, reg_addr, reg_wdata);
      miss_cnt++;
    end
    rst = 1'b0;
    sel_active = 1'b0;
    cycles(3);
    ack_delay = 2;
  endtask

`ifdef SPI_CMD_TIMEOUT_EN
  task automatic test_timeout();
    int hi = 0;
    clear_logs();
    ack_en = 1'b0;
    @(negedge clk) sel_active = 1'b1;
    send_byte(8'h01, 2); send_byte(8'h40, 2); send_byte(8'h99, 0);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (reg_req) hi++;
    end
    vec_cnt++;
    if (hi != 16) begin
      $display("FAIL to_len: got req high %0d cycles, expected 16", hi);
      miss_cnt++;
    end
    ack_en = 1'b1;
    send_byte(8'h55);
    vec_cnt++;
    if (err !== 1'b1 || busy !== 1'b1 || reg_req !== 1'b0 || acc_addr.size() != 0) begin
      $display("FAIL to_drain: got err=%b busy=%b req=%b acc=%0d, expected 1/1/0/0",
               err, busy, reg_req, acc_addr.size());
      miss_cnt++;
    end
    @(negedge clk) sel_active = 1'b0;
    cycles(2);
    vec_cnt++;
    if (busy !== 1'b0) begin
      $display("FAIL to_idle: got busy=%b, expected 0", busy);
      miss_cnt++;
    end
  endtask
`endif

  task automatic test_stability();
    vec_cnt++;
    if (stab_err != 0) begin
      $display("FAIL req_stable: got %0d addr/we/wdata changes under req, expected 0", stab_err);
      miss_cnt++;
    end
  endtask

  initial begin
    test_reset();
    test_write_burst();
    test_read_burst();
    test_bad_opcode_status();
    test_overrun();
    test_deselect_rd_wait();
    test_rst_mid_write();
`ifdef SPI_CMD_TIMEOUT_EN
    test_timeout();
`endif
    test_stability();
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miss_cnt);
    $finish;
  end

endmodule
